// File: rtl/cadence_pkg.sv
// Shared types and constants for the cadence period measurement block.
package cadence_pkg;

    localparam int CAD_CNT_W = 24;
    // Four slots of CAD_CNT_W bits need two extra bits to sum without overflow.
    localparam int CAD_SUM_W = CAD_CNT_W + 2;

    localparam logic [CAD_CNT_W-1:0] CAD_TIMEOUT_FAST = 24'h00_FFFF;
    localparam logic [CAD_CNT_W-1:0] CAD_TIMEOUT_FULL = 24'hFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        MEAS  = 2'd2
    } cad_state_t;

endpackage

// File: rtl/cadence_meas_if.sv
// Cadence measurement bus: filtered rise pulse in, averaged period and status out.
interface cadence_meas_if;
    import cadence_pkg::*;

    logic                 cadence_rise;
    logic [CAD_CNT_W-1:0] cadence_per;
    logic                 cadence_vld;
    logic                 not_pedaling;

    // master: the side producing cadence edges and consuming the measurement.
    modport master (
        output cadence_rise,
        input  cadence_per,
        input  cadence_vld,
        input  not_pedaling
    );

    // slave: the measurement controller.
    modport slave (
        input  cadence_rise,
        output cadence_per,
        output cadence_vld,
        output not_pedaling
    );

endinterface

// File: rtl/cadence_avg4.sv
// Four-slot period history with a registered truncating mean.
module cadence_avg4
    import cadence_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed,
    input  logic                 shift,
    input  logic [CAD_CNT_W-1:0] din,
    output logic [CAD_CNT_W-1:0] avg
);

    logic [CAD_CNT_W-1:0] r_hist [4];
    logic [CAD_CNT_W-1:0] w_hist_next [4];
    logic [CAD_SUM_W-1:0] w_sum;
    logic [CAD_CNT_W-1:0] w_avg_next;
    logic [1:0]           w_unused_frac;
    logic [CAD_CNT_W-1:0] r_avg;

    // Next history: seed fills every slot, shift pushes din in and drops slot 3.
    always_comb begin
        w_hist_next = r_hist;
        if (seed) begin
            for (int i = 0; i < 4; i++) begin
                w_hist_next[i] = din;
            end
        end else if (shift) begin
            w_hist_next[0] = din;
            w_hist_next[1] = r_hist[0];
            w_hist_next[2] = r_hist[1];
            w_hist_next[3] = r_hist[2];
        end
    end

    // Sum the post-update history so the average is ready on the capture edge.
    always_comb begin
        w_sum = {2'b00, w_hist_next[0]} + {2'b00, w_hist_next[1]}
              + {2'b00, w_hist_next[2]} + {2'b00, w_hist_next[3]};
        {w_avg_next, w_unused_frac} = w_sum;
    end

    // History and averaged output registers; the average only moves on capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= '0;
            end
            r_avg <= '0;
        end else begin
            r_hist <= w_hist_next;
            if (seed || shift) begin
                r_avg <= w_avg_next;
            end
        end
    end

    assign avg = r_avg;

endmodule

// File: rtl/cadence_meas.sv
// Cadence period measurement: times crank-edge intervals, averages the last
// four, and flags not_pedaling when edges stop arriving.
module cadence_meas
    import cadence_pkg::*;
#(
    parameter logic FAST_SIM = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    cadence_meas_if.slave  bus
);

    localparam logic [CAD_CNT_W-1:0] TIMEOUT = FAST_SIM ? CAD_TIMEOUT_FAST : CAD_TIMEOUT_FULL;
    localparam logic [CAD_CNT_W-1:0] CNT_ONE = {{(CAD_CNT_W-1){1'b0}}, 1'b1};

    cad_state_t           r_state;
    cad_state_t           w_state_next;
    logic [CAD_CNT_W-1:0] r_cnt;
    logic [CAD_CNT_W-1:0] w_cnt_next;
    logic                 w_rise;
    logic                 w_timeout;
    logic                 w_seed;
    logic                 w_shift;
    logic                 w_not_pedaling;
    logic                 r_vld;
    logic [CAD_CNT_W-1:0] w_avg;

    assign w_rise    = bus.cadence_rise;
    assign w_timeout = (r_cnt == TIMEOUT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a rise always beats a coincident timeout.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_rise) w_state_next = ARMED;
            end
            ARMED: begin
                if (w_rise)         w_state_next = MEAS;
                else if (w_timeout) w_state_next = IDLE;
            end
            MEAS: begin
                if (!w_rise && w_timeout) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: first captured period seeds the history, later ones shift in.
    always_comb begin
        w_seed         = (r_state == ARMED) && w_rise;
        w_shift        = (r_state == MEAS) && w_rise;
        w_not_pedaling = (r_state != MEAS);
    end

    // Counter next value; saturation is implied by leaving for IDLE at TIMEOUT.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_state == IDLE) begin
            w_cnt_next = w_rise ? CNT_ONE : '0;
        end else if (w_rise) begin
            w_cnt_next = CNT_ONE;
        end else if (w_timeout) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + CNT_ONE;
        end
    end

    // Interval counter and capture strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_vld <= w_seed || w_shift;
        end
    end

    cadence_avg4 u_avg4 (
        .clk   (clk),
        .rst   (rst),
        .seed  (w_seed),
        .shift (w_shift),
        .din   (r_cnt),
        .avg   (w_avg)
    );

    assign bus.cadence_per  = w_avg;
    assign bus.cadence_vld  = r_vld;
    assign bus.not_pedaling = w_not_pedaling;

endmodule

// File: tb/tb_cadence_meas.sv
// Directed bench for cadence_meas with FAST_SIM timeout (65535 cycles).
module tb_cadence_meas;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    cadence_meas_if bus_if ();

    cadence_meas #(
        .FAST_SIM (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One-cycle rise pulse sampled at the next edge.
    task automatic rise();
        bus_if.cadence_rise = 1'b1;
        step();
        bus_if.cadence_rise = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus_if.cadence_rise = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if (bus_if.cadence_per !== 24'd0 || bus_if.cadence_vld !== 1'b0
                || bus_if.not_pedaling !== 1'b1) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: per=%0d vld=%b np=%b, want per=0 vld=0 np=1",
                         i, bus_if.cadence_per, bus_if.cadence_vld, bus_if.not_pedaling);
            end
        end
    endtask

    task automatic test_basic();
        rise();
        n_vec++;
        if (bus_if.cadence_vld !== 1'b0 || bus_if.not_pedaling !== 1'b1) begin
            n_err++;
            $display("FAIL first_rise: vld=%b np=%b, want vld=0 np=1",
                     bus_if.cadence_vld, bus_if.not_pedaling);
        end
        idle(999);
        n_vec++;
        if (bus_if.cadence_vld !== 1'b0 || bus_if.not_pedaling !== 1'b1) begin
            n_err++;
            $display("FAIL armed_hold: vld=%b np=%b, want vld=0 np=1",
                     bus_if.cadence_vld, bus_if.not_pedaling);
        end
        rise();
        n_vec++;
        if (bus_if.cadence_vld !== 1'b1 || bus_if.cadence_per !== 24'd1000
            || bus_if.not_pedaling !== 1'b0) begin
            n_err++;
            $display("FAIL seed_1000: vld=%b per=%0d np=%b, want vld=1 per=1000 np=0",
                     bus_if.cadence_vld, bus_if.cadence_per, bus_if.not_pedaling);
        end
        step();
        n_vec++;
        if (bus_if.cadence_vld !== 1'b0 || bus_if.not_pedaling !== 1'b0) begin
            n_err++;
            $display("FAIL vld_one_cycle: vld=%b np=%b, want vld=0 np=0",
                     bus_if.cadence_vld, bus_if.not_pedaling);
        end
        idle(998);
        rise();
        n_vec++;
        if (bus_if.cadence_vld !== 1'b1 || bus_if.cadence_per !== 24'd1000) begin
            n_err++;
            $display("FAIL second_1000: vld=%b per=%0d, want vld=1 per=1000",
                     bus_if.cadence_vld, bus_if.cadence_per);
        end
    endtask

    task automatic test_average();
        logic [23:0] exp_avg [4] = '{24'd1250, 24'd1500, 24'd1750, 24'd2000};
        do_reset();
        rise();
        idle(999);
        rise();
        n_vec++;
        if (bus_if.cadence_per !== 24'd1000) begin
            n_err++;
            $display("FAIL avg_seed: per=%0d, want 1000", bus_if.cadence_per);
        end
        for (int k = 0; k < 4; k++) begin
            idle(1999);
            rise();
            n_vec++;
            if (bus_if.cadence_vld !== 1'b1 || bus_if.cadence_per !== exp_avg[k]) begin
                n_err++;
                $display("FAIL avg_step%0d: vld=%b per=%0d, want vld=1 per=%0d",
                         k, bus_if.cadence_vld, bus_if.cadence_per, exp_avg[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int bad = -1;
        do_reset();
        rise();
        idle(99);
        rise();
        n_vec++;
        if (bus_if.cadence_per !== 24'd100 || bus_if.not_pedaling !== 1'b0) begin
            n_err++;
            $display("FAIL to_seed: per=%0d np=%b, want per=100 np=0",
                     bus_if.cadence_per, bus_if.not_pedaling);
        end
        for (int j = 1; j <= 65534; j++) begin
            step();
            if (bad < 0 && (bus_if.not_pedaling !== 1'b0 || bus_if.cadence_vld !== 1'b0)) begin
                bad = j;
            end
        end
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL to_early: np/vld changed %0d cycles after rise, want np=0 vld=0 to 65534",
                     bad);
        end
        step();
        n_vec++;
        if (bus_if.not_pedaling !== 1'b1) begin
            n_err++;
            $display("FAIL to_edge: np=%b at 65535 cycles after rise, want 1",
                     bus_if.not_pedaling);
        end
        idle(9);
        rise();
        n_vec++;
        if (bus_if.cadence_vld !== 1'b0 || bus_if.not_pedaling !== 1'b1) begin
            n_err++;
            $display("FAIL to_rearm: vld=%b np=%b, want vld=0 np=1",
                     bus_if.cadence_vld, bus_if.not_pedaling);
        end
        idle(299);
        rise();
        n_vec++;
        if (bus_if.cadence_vld !== 1'b1 || bus_if.cadence_per !== 24'd300
            || bus_if.not_pedaling !== 1'b0) begin
            n_err++;
            $display("FAIL to_fresh: vld=%b per=%0d np=%b, want vld=1 per=300 np=0",
                     bus_if.cadence_vld, bus_if.cadence_per, bus_if.not_pedaling);
        end
    endtask

    // Runs straight after test_timeout: history holds 300 x4, cnt restarted at 1.
    task automatic test_coincident();
        int bad = -1;
        for (int j = 1; j <= 65534; j++) begin
            step();
            if (bad < 0 && (bus_if.not_pedaling !== 1'b0 || bus_if.cadence_vld !== 1'b0)) begin
                bad = j;
            end
        end
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL co_wait: np/vld changed %0d cycles after rise, want np=0 vld=0", bad);
        end
        rise();
        n_vec++;
        // (300*3 + 65535) / 4 = 16608.75 -> 16608
        if (bus_if.cadence_vld !== 1'b1 || bus_if.cadence_per !== 24'd16608
            || bus_if.not_pedaling !== 1'b0) begin
            n_err++;
            $display("FAIL co_capture: vld=%b per=%0d np=%b, want vld=1 per=16608 np=0",
                     bus_if.cadence_vld, bus_if.cadence_per, bus_if.not_pedaling);
        end
        step();
        n_vec++;
        if (bus_if.cadence_vld !== 1'b0 || bus_if.not_pedaling !== 1'b0) begin
            n_err++;
            $display("FAIL co_no_idle: vld=%b np=%b, want vld=0 np=0",
                     bus_if.cadence_vld, bus_if.not_pedaling);
        end
        idle(10);
        n_vec++;
        if (bus_if.not_pedaling !== 1'b0 || bus_if.cadence_per !== 24'd16608) begin
            n_err++;
            $display("FAIL co_hold: np=%b per=%0d, want np=0 per=16608",
                     bus_if.not_pedaling, bus_if.cadence_per);
        end
    endtask

    task automatic test_reset_mid();
        idle(49);
        rst = 1'b1;
        bus_if.cadence_rise = 1'b1;
        step();
        rst = 1'b0;
        bus_if.cadence_rise = 1'b0;
        n_vec++;
        if (bus_if.cadence_per !== 24'd0 || bus_if.cadence_vld !== 1'b0
            || bus_if.not_pedaling !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid: per=%0d vld=%b np=%b, want per=0 vld=0 np=1",
                     bus_if.cadence_per, bus_if.cadence_vld, bus_if.not_pedaling);
        end
        step();
        rise();
        n_vec++;
        if (bus_if.cadence_vld !== 1'b0 || bus_if.not_pedaling !== 1'b1) begin
            n_err++;
            $display("FAIL rst_idle_rise: vld=%b np=%b, want vld=0 np=1",
                     bus_if.cadence_vld, bus_if.not_pedaling);
        end
        idle(499);
        rise();
        n_vec++;
        if (bus_if.cadence_vld !== 1'b1 || bus_if.cadence_per !== 24'd500
            || bus_if.not_pedaling !== 1'b0) begin
            n_err++;
            $display("FAIL rst_reseed: vld=%b per=%0d np=%b, want vld=1 per=500 np=0",
                     bus_if.cadence_vld, bus_if.cadence_per, bus_if.not_pedaling);
        end
    endtask

    initial begin
        bus_if.cadence_rise = 1'b0;
        test_reset();
        test_basic();
        test_average();
        test_timeout();
        test_coincident();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
